inst_fetch: RTL and testbench

//  Consumer side of the program-counter register: samples the current PC, drives
//  the instruction-memory request/ack handshake and returns each fetched word to

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_out_reg.sv | 37 +++
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: default widths, the NOP word and the fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StDrop    = 3'd2,
    StHold    = 3'd3,
    StErrWait = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Output holding register towards decode: loads a fetched word, clears valid on hand-off.
module fetch_out_reg #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [DATA_W-1:0]     NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              load_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
      out_pc    <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_inst  <= load_inst;
      out_pc    <= load_pc;
      out_err   <= load_err;
    end else if (clear) begin
      // Payload is left in place; only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: samples the PC, runs the imem req/ack handshake and hands words to decode.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err,
  output logic              busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pc_ena_q, pc_ena_d;
  logic              ld, clr, ld_err;
  logic [DATA_W-1:0] ld_inst;
  logic [ADDR_W-1:0] ld_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      pc_ena_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pc_ena_q <= pc_ena_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pc_ena_d = 1'b0;
    ld       = 1'b0;
    clr      = 1'b0;
    ld_inst  = imem_rdata;
    ld_pc    = addr_q;
    ld_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && !flush) begin
          addr_d = pc;
          if (pc[1:0] != 2'b00) begin
            // Misaligned: report straight to decode without touching memory.
            ld      = 1'b1;
            ld_inst = NOP_INST;
            ld_pc   = pc;
            ld_err  = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (imem_ack) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            ld       = 1'b1;
            pc_ena_d = 1'b1;
            state_d  = StHold;
          end
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_ack) state_d = StIdle;
      end
      StHold: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = StIdle;
        end else if (out_ready) begin
          clr     = 1'b1;
          state_d = out_err ? StErrWait : StIdle;
        end
      end
      StErrWait: begin
        if (flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc_ena    = pc_ena_q;
  assign imem_req  = (state_q == StReq) || (state_q == StDrop);
  assign imem_addr = addr_q;
  assign busy      = (state_q != StIdle);

  fetch_out_reg #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NOP_INST(NOP_INST)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .clear    (clr),
    .load_inst(ld_inst),
    .load_pc  (ld_pc),
    .load_err (ld_err),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .out_err  (out_err)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized fetches vs a model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int ena_cnt = 0;
  int exp_ena = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } fetch_t;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .pc        (pc),
    .pc_ena    (pc_ena),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pc_ena === 1'b1) ena_cnt++;
  end

  // What decode should see for a fetch from address a when memory returns d.
  function automatic fetch_t expect_fetch(logic [31:0] a, logic [31:0] d);
    fetch_t r;
    r.err  = (a % 4) != 0;
    r.inst = r.err ? 32'h0000_0000 : d;
    r.pc   = a;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int waits,
                          input int hold, input bit flush_acc);
    fetch_t e;
    e  = expect_fetch(a, d);
    pc = a;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("req_raised", imem_req, 1);
    check("req_addr", imem_addr, a);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("req_held", {pc_ena, imem_req, imem_addr}, {1'b0, 1'b1, a});
    end
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    exp_ena++;
    check("out_valid", out_valid, 1);
    check("out_inst", out_inst, e.inst);
    check("out_pc", out_pc, e.pc);
    check("out_err", out_err, e.err);
    check("pc_ena_pulse", pc_ena, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {out_valid, out_err, out_inst, out_pc[30:0]},
            {1'b1, e.err, e.inst, e.pc[30:0]});
      check("hold_quiet", {pc_ena, imem_req}, 2'b00);
    end
    out_ready = 1'b1;
    flush     = flush_acc;
    tick();
    out_ready = 1'b0;
    flush     = 1'b0;
    check("accepted", {out_valid, busy, pc_ena}, 3'b000);
  endtask

  initial begin
    logic [31:0] a;

    // Test 1: reset values, then reset in the middle of a request.
    #3 rst = 1'b0;
    tick();
    check("rst_outputs", {pc_ena, imem_req, out_valid, out_err, busy}, 5'b0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_addr", {imem_addr, out_pc}, 64'h0);
    rst = 1'b1;
    tick();
    pc = 32'h40;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t1_req", imem_req, 1);
    rst = 1'b0;
    #2;
    check("t1_async_rst", {imem_req, busy}, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    check("t1_after_rst", {imem_req, out_valid, busy}, 3'b000);
    check("t1_inst", out_inst, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("t1_late_ack", {pc_ena, out_valid, busy}, 3'b000);

    // Test 2/3: 0 and 3 wait cycles, then decode stalls for 5 cycles.
    do_fetch(32'h100, 32'h0bad_f00d, 0, 0, 1'b0);
    do_fetch(32'h104, 32'h1357_9bdf, 3, 0, 1'b0);
    do_fetch(32'h108, 32'h2468_ace0, 1, 5, 1'b0);

    // Test 4: flush one cycle before the ack.
    pc = 32'h180;
    en = 1'b1;
    tick();
    en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_drop_req", {imem_req, busy, imem_addr}, {1'b1, 1'b1, 32'h180});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_drop_reflush", {imem_req, busy}, 2'b11);
    imem_ack   = 1'b1;
    imem_rdata = 32'hdead_beef;
    tick();
    imem_ack = 1'b0;
    check("t4_discarded", {pc_ena, out_valid, busy}, 3'b000);
    do_fetch(32'h200, 32'h0000_0013, 0, 1, 1'b0);

    // Test 5: misaligned PC.
    pc = 32'h102;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t5_no_req", {imem_req, pc_ena}, 2'b00);
    check("t5_err", {out_valid, out_err}, 2'b11);
    check("t5_inst", out_inst, 32'h0);
    check("t5_pc", out_pc, 32'h102);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_accepted", {out_valid, busy}, 2'b01);
    en = 1'b1;
    repeat (3) tick();
    check("t5_errwait", {imem_req, out_valid, busy}, 3'b001);
    en    = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flushed", busy, 0);

    // Test 6: flush with ack, and flush with out_ready.
    pc = 32'h300;
    en = 1'b1;
    tick();
    en         = 1'b0;
    imem_ack   = 1'b1;
    flush      = 1'b1;
    imem_rdata = 32'hcafe_f00d;
    tick();
    imem_ack = 1'b0;
    flush    = 1'b0;
    check("t6_flush_ack", {pc_ena, out_valid, busy}, 3'b000);
    do_fetch(32'h304, 32'h5555_aaaa, 2, 2, 1'b1);

    // Randomized sequential fetches, PC advancing as the PC register would.
    a = {$urandom_range(0, 16'hffff), 2'b00};
    for (int i = 0; i < 8; i++) begin
      do_fetch(a, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      a = a + 32'd4;
    end

    tick();
    check("pc_ena_total", ena_cnt, exp_ena);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
